// File: rtl/aes_inv_key_sequencer.sv
// AES-128 round-key sequencer for the inverse cipher: expands a cipher key into an
// 11-entry store, one round key per cycle, then replays it in reverse round order.
module aes_inv_key_sequencer #(
  parameter int NR = 10,
  parameter int KW = 128
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_load,
  input  logic [KW-1:0] i_key,
  output logic          o_key_ready,
  input  logic          i_start,
  output logic          o_init,
  output logic [3:0]    o_round,
  output logic [KW-1:0] o_roundkey,
  output logic          o_busy
);

  // state  | meaning
  // EMPTY  | no valid key schedule
  // EXPAND | computing rk1..rk10, one per cycle
  // READY  | schedule valid, idle, presenting rk10
  // RUN    | stepping o_round 0..10 with rk[10-o_round]
  typedef enum logic [1:0] {EMPTY, EXPAND, READY, RUN} state_e;

  localparam logic [3:0] NR_L = 4'(NR);

  state_e        state_q, state_d;
  logic [3:0]    cnt_q, cnt_d;
  logic [3:0]    round_q, round_d;
  logic          init_q, init_d;
  logic [KW-1:0] rk_q [NR+1];
  logic [KW-1:0] rk_d [NR+1];
  logic [KW-1:0] rk_prev;
  logic [KW-1:0] rk_next;
  logic [31:0]   w0_n, w1_n, w2_n, w3_n;

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] a_s;
    p   = '0;
    a_s = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ a_s;
      a_s = {a_s[6:0], 1'b0} ^ (a_s[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  // Multiplicative inverse as x^254 (zero maps to zero), then the affine transform.
  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [7:0] inv;
    logic [7:0] sq;
    inv = 8'h01;
    sq  = x;
    for (int i = 1; i < 8; i++) begin
      sq  = gf_mul(sq, sq);
      inv = gf_mul(inv, sq);
    end
    return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
           {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
  endfunction

  function automatic logic [7:0] rcon(input logic [3:0] idx);
    logic [7:0] r;
    case (idx)
      4'd1:    r = 8'h01;
      4'd2:    r = 8'h02;
      4'd3:    r = 8'h04;
      4'd4:    r = 8'h08;
      4'd5:    r = 8'h10;
      4'd6:    r = 8'h20;
      4'd7:    r = 8'h40;
      4'd8:    r = 8'h80;
      4'd9:    r = 8'h1b;
      4'd10:   r = 8'h36;
      default: r = 8'h00;
    endcase
    return r;
  endfunction

  always_comb begin
    rk_prev = rk_q[cnt_q - 4'd1];
    w0_n    = rk_prev[127:96] ^ sub_word({rk_prev[23:0], rk_prev[31:24]}) ^ {rcon(cnt_q), 24'h0};
    w1_n    = rk_prev[95:64] ^ w0_n;
    w2_n    = rk_prev[63:32] ^ w1_n;
    w3_n    = rk_prev[31:0]  ^ w2_n;
    rk_next = {w0_n, w1_n, w2_n, w3_n};
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    round_d = round_q;
    init_d  = 1'b0;
    rk_d    = rk_q;
    case (state_q)
      EMPTY: begin
        if (i_load) begin
          rk_d[0] = i_key;
          cnt_d   = 4'd1;
          state_d = EXPAND;
        end
      end
      EXPAND: begin
        rk_d[cnt_q] = rk_next;
        cnt_d       = cnt_q + 4'd1;
        if (cnt_q == NR_L) begin
          cnt_d   = '0;
          state_d = READY;
        end
      end
      READY: begin
        // A re-key takes priority over a decrypt request in the same cycle.
        if (i_load) begin
          rk_d[0] = i_key;
          cnt_d   = 4'd1;
          state_d = EXPAND;
        end else if (i_start) begin
          init_d  = 1'b1;
          round_d = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        if (round_q == NR_L) begin
          round_d = '0;
          state_d = READY;
        end else begin
          round_d = round_q + 4'd1;
        end
      end
      default: state_d = EMPTY;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      state_q <= EMPTY;
      cnt_q   <= '0;
      round_q <= '0;
      init_q  <= 1'b0;
      rk_q    <= '{default: '0};
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      round_q <= round_d;
      init_q  <= init_d;
      rk_q    <= rk_d;
    end
  end

  assign o_init      = init_q;
  assign o_round     = round_q;
  assign o_busy      = (state_q == EXPAND) || (state_q == RUN);
  assign o_key_ready = (state_q == READY);
  assign o_roundkey  = ((state_q == READY) || (state_q == RUN)) ? rk_q[NR_L - round_q] : '0;

endmodule
